// File: rtl/axi_tensor_rd.sv
// AXI4 single-burst tensor reader that fills the 8x8 PE accumulator preload image.
package params;
    typedef enum logic [1:0] {
        DTYPE_INT8 = 2'd0,
        DTYPE_FP16 = 2'd1,
        DTYPE_BF16 = 2'd2,
        DTYPE_FP32 = 2'd3
    } dtype_t;

    typedef struct packed {
        dtype_t     datatype;
        logic [7:0] stride;
        logic [7:0] count;
    } addrgen_t;
endpackage

module axi_tensor_rd #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mixed,
    input  logic                    rd_enb,
    input  params::addrgen_t        addr_type,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    input  logic [31:0]             axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    output logic [7:0][7:0][127:0]  regfiles,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int unsigned BEAT_W = 9;
    localparam int unsigned PE_W   = 6;
    localparam int unsigned WAVE_W = 2;
    localparam logic [BEAT_W-1:0] LAST_NORMAL  = BEAT_W'(255);
    localparam logic [BEAT_W-1:0] LAST_SPECIAL = BEAT_W'(127);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_ADDR = 2'd1,
        READ_DATA = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q;
    logic                    special_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]              arlen_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [PE_W-1:0]         pe_q;
    logic [WAVE_W-1:0]       wave_q;
    logic [7:0][7:0][127:0]  rf_q;

    logic start_c, accept_c, final_c, beat_err_c, special_c;
    logic unused_addr_type;

    assign special_c  = ~mixed && (addr_type.datatype == params::DTYPE_FP16);
    assign start_c    = (state_q == IDLE) && rd_enb;
    assign accept_c   = rready_q && axi_rvalid;
    assign final_c    = (beat_q == (special_q ? LAST_SPECIAL : LAST_NORMAL));
    assign beat_err_c = (axi_rresp != 2'b00) || (axi_rlast != final_c);

    assign unused_addr_type = ^{addr_type.stride, addr_type.count};

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = araddr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = 3'b010;
    assign axi_arburst = 2'b01;
    assign axi_rready  = rready_q;
    assign regfiles    = rf_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; the burst ends on beat count alone, never on rlast
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (rd_enb) state_d = READ_ADDR;
            READ_ADDR: if (arvalid_q && axi_arready) state_d = READ_DATA;
            READ_DATA: if (accept_c && final_c) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        arvalid_d = (state_d == READ_ADDR);
        rready_d  = (state_d == READ_DATA);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == READ_DATA) && accept_c && final_c;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Load parameters, beat/PE/wave counters, error flag and regfile image
    always_ff @(posedge clk) begin
        if (rst) begin
            special_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= 8'hFF;
            beat_q    <= '0;
            pe_q      <= '0;
            wave_q    <= '0;
            err_q     <= 1'b0;
            rf_q      <= '0;
        end else if (start_c) begin
            special_q <= special_c;
            araddr_q  <= base_addr;
            arlen_q   <= special_c ? 8'h7F : 8'hFF;
            beat_q    <= '0;
            pe_q      <= '0;
            wave_q    <= '0;
            err_q     <= 1'b0;
            rf_q      <= '0;
        end else if (accept_c) begin
            beat_q <= beat_q + BEAT_W'(1);
            pe_q   <= pe_q + PE_W'(1);
            if (pe_q == PE_W'(63)) wave_q <= wave_q + WAVE_W'(1);
            if (beat_err_c) err_q <= 1'b1;
            if (special_q) begin
                // FP16 halves land in the low half of each 32-bit lane pair
                rf_q[pe_q[5:3]][pe_q[2:0]][{wave_q[0], 6'd0}  +: 16] <= axi_rdata[15:0];
                rf_q[pe_q[5:3]][pe_q[2:0]][{wave_q[0], 6'd32} +: 16] <= axi_rdata[31:16];
            end else begin
                rf_q[pe_q[5:3]][pe_q[2:0]][{wave_q, 5'd0} +: 32] <= axi_rdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_tensor_rd.sv
// Directed/randomized bench for axi_tensor_rd with a beat-level regfile reference model.
module tb_axi_tensor_rd;
    import params::*;

    localparam int unsigned AW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mixed;
    logic                  rd_enb;
    addrgen_t              addr_type;
    logic [AW-1:0]         base_addr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [AW-1:0]         axi_araddr;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [31:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic [7:0][7:0][127:0] regfiles;
    logic                  busy;
    logic                  load_done;
    logic                  load_err;

    int tests = 0;
    int fails = 0;
    int ar_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    axi_tensor_rd #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .mixed(mixed), .rd_enb(rd_enb),
        .addr_type(addr_type), .base_addr(base_addr),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .regfiles(regfiles), .busy(busy), .load_done(load_done), .load_err(load_err)
    );

    // Count AR handshakes and done pulses on the clock edge where the DUT sees them
    always @(posedge clk) begin
        if (axi_arvalid && axi_arready) ar_cnt <= ar_cnt + 1;
        if (load_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // data_mode: 0 -> rdata=k, 1 -> fixed fdata, 2 -> random
    task automatic do_load(input logic [31:0] base, input logic mix, input dtype_t dt,
                           input int ar_stall, input bit toggle, input int data_mode,
                           input logic [31:0] fdata, input int bad_resp, input int bad_last,
                           input int rst_beat, input int ign_beat);
        logic [127:0] exp_rf [64];
        logic [31:0]  d;
        bit           spec, exp_err, last, aborted;
        int           total, pe, w, ar0, d0, waitc;

        spec    = !mix && (dt == DTYPE_FP16);
        total   = spec ? 128 : 256;
        exp_err = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < 64; i++) exp_rf[i] = '0;
        ar0 = ar_cnt;
        d0  = done_cnt;

        mixed              = mix;
        addr_type.datatype = dt;
        addr_type.stride   = 8'($urandom);
        addr_type.count    = 8'($urandom);
        base_addr          = base;
        rd_enb             = 1'b1;
        tick();
        rd_enb    = 1'b0;
        base_addr = $urandom;
        mixed     = ~mix;
        addr_type.datatype = spec ? DTYPE_INT8 : DTYPE_FP16;

        chk("start_busy", busy, 1);
        chk("start_arvalid", axi_arvalid, 1);
        chk("start_err_clear", load_err, 0);
        chk("araddr", axi_araddr, base);
        chk("arlen", axi_arlen, spec ? 127 : 255);
        chk("arsize", axi_arsize, 3'b010);
        chk("arburst", axi_arburst, 2'b01);
        chk("ar_rready_low", axi_rready, 0);

        axi_arready = 1'b0;
        for (int i = 0; i < ar_stall; i++) begin
            tick();
            chk("ar_stall_arvalid", axi_arvalid, 1);
            chk("ar_stall_araddr", axi_araddr, base);
        end
        axi_arready = 1'b1;
        waitc = 0;
        tick();
        axi_arready = 1'b0;
        chk("ar_done_arvalid", axi_arvalid, 0);
        chk("rd_rready", axi_rready, 1);

        for (int k = 0; k < total; k++) begin
            if (k == rst_beat) begin
                rst        = 1'b1;
                axi_rvalid = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_arvalid", axi_arvalid, 0);
                chk("rst_rready", axi_rready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", load_done, 0);
                chk("rst_err", load_err, 0);
                chk("rst_araddr", axi_araddr, 0);
                for (int i = 0; i < 64; i++)
                    chk($sformatf("rst_rf%0d", i), regfiles[i/8][i%8], 0);
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("post_rst_rready", axi_rready, 0);
                    chk("post_rst_busy", busy, 0);
                end
                axi_rvalid = 1'b0;
                tick();
                chk("rst_no_done", done_cnt - d0, 0);
                aborted = 1'b1;
                break;
            end
            if (toggle && (k % 2 == 1)) begin
                axi_rvalid = 1'b0;
                tick();
                chk("gap_rready", axi_rready, 1);
            end
            if (k == ign_beat) begin
                rd_enb    = 1'b1;
                base_addr = base ^ 32'hFFFF_0000;
            end
            case (data_mode)
                0:       d = 32'(k);
                1:       d = fdata;
                default: d = $urandom;
            endcase
            last = (k == total - 1) ^ (k == bad_last);
            pe = k % 64;
            w  = k / 64;
            if (spec) begin
                exp_rf[pe][w*64 +: 16]      = d[15:0];
                exp_rf[pe][w*64 + 32 +: 16] = d[31:16];
            end else begin
                exp_rf[pe][w*32 +: 32] = d;
            end
            if (k == bad_resp || last != (k == total - 1)) exp_err = 1'b1;
            axi_rvalid = 1'b1;
            axi_rdata  = d;
            axi_rresp  = (k == bad_resp) ? 2'b10 : 2'b00;
            axi_rlast  = last;
            chk("beat_rready", axi_rready, 1);
            tick();
            if (k == ign_beat) begin
                rd_enb = 1'b0;
                chk("ign_arvalid", axi_arvalid, 0);
                chk("ign_busy", busy, 1);
            end
            if (k < total - 1) chk("early_done", load_done, 0);
        end

        if (!aborted) begin
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
            axi_rresp  = 2'b00;
            chk("done_pulse", load_done, 1);
            chk("done_busy", busy, 0);
            chk("load_err", load_err, exp_err);
            tick();
            chk("done_drop", load_done, 0);
            chk("idle_rready", axi_rready, 0);
            tick();
            chk("ar_count", ar_cnt - ar0, 1);
            chk("done_count", done_cnt - d0, 1);
            for (int i = 0; i < 64; i++)
                chk($sformatf("rf%0d", i), regfiles[i/8][i%8], exp_rf[i]);
        end
    endtask

    initial begin
        rst         = 1'b1;
        mixed       = 1'b0;
        rd_enb      = 1'b0;
        addr_type   = '0;
        base_addr   = '0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_rlast   = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_arvalid", axi_arvalid, 0);
        chk("reset_rready", axi_rready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", load_done, 0);
        chk("reset_err", load_err, 0);
        chk("reset_araddr", axi_araddr, 0);
        chk("reset_rf00", regfiles[0][0], 0);
        chk("reset_rf77", regfiles[7][7], 0);
        rst = 1'b0;
        tick();

        // Normal load, rdata = beat index
        do_load(32'h1000, 1'b1, DTYPE_FP16, 0, 1'b0, 0, 32'h0, -1, -1, -1, -1);
        chk("normal_rf00_lo", regfiles[0][0][31:0], 32'd0);
        chk("normal_rf77_hi", regfiles[7][7][127:96], 32'd255);
        repeat (4) tick();
        chk("hold_rf77_hi", regfiles[7][7][127:96], 32'd255);

        // Special FP16 load with a fixed pattern
        do_load(32'h2000, 1'b0, DTYPE_FP16, 0, 1'b0, 1, 32'hBBBB_AAAA, -1, -1, -1, -1);
        chk("special_rf26", regfiles[2][6], 128'h0000BBBB0000AAAA0000BBBB0000AAAA);

        // Backpressure on AR and R, same data as the normal case
        do_load(32'h1000, 1'b1, DTYPE_INT8, 5, 1'b1, 0, 32'h0, -1, -1, -1, -1);
        chk("bp_rf77_hi", regfiles[7][7][127:96], 32'd255);

        // Error on rresp, then error on early rlast
        do_load(32'h3000, 1'b0, DTYPE_INT8, 1, 1'b0, 2, 32'h0, 10, -1, -1, -1);
        do_load(32'h4000, 1'b1, DTYPE_FP32, 0, 1'b0, 2, 32'h0, -1, 100, -1, -1);

        // Reset mid-load, then a clean load with an ignored restart
        do_load(32'h5000, 1'b1, DTYPE_INT8, 0, 1'b0, 2, 32'h0, -1, -1, 50, -1);
        do_load(32'h6000, 1'b0, DTYPE_BF16, 2, 1'b0, 2, 32'h0, -1, -1, -1, 20);

        // Random special load with R backpressure
        do_load(32'h7000, 1'b0, DTYPE_FP16, 3, 1'b1, 2, 32'h0, -1, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
